adc_frame_packer: RTL and testbench
===================================

// Module: adc_frame_packer
// PURPOSE
//  Parametrised successor to the AD7768-4 capture path. Deserialises NUM_CH serial ADC lanes framed by nDRDY/DCLK,
//  strips the per-sample header and truncates each sample to OUT_BITS.
//  Emits one word per enabled channel on a valid/ready stream into the acquisition FIFO.
//  Adds a channel-enable mask, backpressure, and frame-drop accounting. All logic runs on clk; ADC inputs are synchronised.
// PARAMETERS
//  NUM_CH       4   number of serial data lanes (1..8)
//  SAMPLE_BITS  32  bits per sample frame per lane (header + value)
//  HDR_BITS     8   leading header bits discarded
//  OUT_BITS     16  emitted width; MSBs of value field, 1..SAMPLE_BITS-HDR_BITS
//  SYNC_STAGES  2   flip-flop synchroniser depth on adc_dclk/adc_n_drdy/adc_dout
//  CNT_W        16  width of drop counter
// PORTS
//  clk          in   1               100 MHz system clock
//  n_reset      in   1               synchronous active-low reset
//  adc_clk      out  1               clk/4 (bit1 of 2-bit divider) to ADC MCLK
//  adc_n_reset  out  1               registered copy of n_reset to ADC
//  adc_n_drdy   in   1               ADC frame marker (async)
//  adc_dclk     in   1               ADC bit clock (async, <= clk/8)
//  adc_dout     in   NUM_CH          ADC serial lanes, MSB first (async)
//  acq_en       in   1               acquisition enable from control
//  ch_mask      in   NUM_CH          1 = channel emitted; sampled at frame completion
//  out_data     out  OUT_BITS        truncated sample
//  out_chan     out  3               channel index of out_data
//  out_last     out  1               high on final enabled channel of frame
//  out_valid    out  1               word available
//  out_ready    in   1               consumer accepts when valid&ready
//  drop_count   out  CNT_W           frames lost to overrun, saturating
//  overrun      out  1               sticky; set on any drop
//  clr_stats    in   1               clears drop_count and overrun
// BEHAVIOUR
//  Reset (n_reset=0 at posedge clk): all outputs 0, adc_n_reset=0, divider=0, both FSMs idle, shift regs 0.
//  Inputs pass SYNC_STAGES flops; dclk falling edge = prev sync 1 & cur sync 0 (one-cycle strobe).
//  Capture FSM:
//   CAP_IDLE: on dclk fall with sync nDRDY=1 -> shift bit 0 of every lane, bit_cnt=1, go CAP_SHIFT.
//   CAP_SHIFT: each dclk fall shifts lanes left, bit_cnt++; after bit_cnt reaches SAMPLE_BITS -> CAP_DONE.
//   CAP_DONE (1 cycle): if acq_en=1 and ch_mask!=0 -> hand off; else discard silently. -> CAP_IDLE.
//  Hand-off: if emit FSM idle, value fields [SAMPLE_BITS-HDR_BITS-1 -: OUT_BITS] of all lanes
//   plus ch_mask copied to hold buffer; else frame dropped, drop_count+1 (saturate at all-ones), overrun=1.
//  Emit FSM:
//   EM_IDLE: hold buffer loaded -> EM_SEND at lowest set mask bit; out_valid=1 on cycle after CAP_DONE.
//   EM_SEND: out_data/out_chan/out_last stable while out_valid & !out_ready.
//    On accept: advance to next set mask bit (same cycle's next word presented next cycle, no bubble).
//    After accepting out_last word -> EM_IDLE, out_valid=0.
//  Latency: last dclk fall -> out_valid high = SYNC_STAGES+3 clk.
//  acq_en falling mid-frame or mid-emit: current frame completes; acq_en only gates at CAP_DONE.
//  clr_stats same cycle as a drop: clear wins, then drop registered next drop only.
//  Mask change mid-emission: no effect on buffered frame.
//  Reset mid-frame or mid-emission: partial frame discarded, out_valid deasserts immediately.
// TESTING
//  1 NUM_CH=4, mask=4'b0111, acq_en=1, lanes ch0..3 = 32'hA5123456, 32'hA5ABCDEF, 32'h00FFFF00, 32'h11111111, ready=1
//    -> words 16'h1234 ch0, 16'hABCD ch1, 16'hFFFF ch2 (out_last=1), no ch3.
//  2 Same frame, ready low 10 clk on 2nd word -> 16'hABCD held stable 10 clk, then 16'hFFFF; drop_count=0.
//  3 ready=0 permanently, 3 consecutive frames -> first frame held, drop_count=2, overrun=1.
//    Then clr_stats pulse -> both 0.
//  4 acq_en=0 during CAP_DONE -> no out_valid, drop_count unchanged; acq_en=1 next frame -> normal emit.
//  5 Reset asserted at bit 17 of a frame -> all outputs 0, next full frame with 32'hA5123456 on ch0,
//    mask=1 -> single word 16'h1234, out_last=1.
//  6 OUT_BITS=24, mask=4'b1000, ch3=32'h7F800001 -> single word 24'h800001, out_chan=3, out_last=1.

Source files
------------

// File: rtl/adc_frame_packer.sv
// Deserialises NUM_CH framed serial ADC lanes, keeps the MSBs of each value field and
// streams one word per enabled channel on valid/ready, counting frames lost to overrun.
module adc_frame_packer #(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_BITS = 32,
    parameter int HDR_BITS    = 8,
    parameter int OUT_BITS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                n_reset,
    output logic                adc_clk,
    output logic                adc_n_reset,
    input  logic                adc_n_drdy,
    input  logic                adc_dclk,
    input  logic [NUM_CH-1:0]   adc_dout,
    input  logic                acq_en,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic [OUT_BITS-1:0] out_data,
    output logic [2:0]          out_chan,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overrun,
    input  logic                clr_stats
);
    // Header bits simply fall off the top of a value-width shift register.
    localparam int VAL_W  = SAMPLE_BITS - HDR_BITS;
    localparam int BCNT_W = $clog2(SAMPLE_BITS + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {CAP_IDLE = 2'd0, CAP_SHIFT = 2'd1, CAP_DONE = 2'd2} cap_state_t;
    typedef enum logic {EM_IDLE = 1'b0, EM_SEND = 1'b1} em_state_t;

    cap_state_t          cap_state_r;
    em_state_t           em_state_r;
    logic [1:0]          div_r;
    logic [SYNC_STAGES-1:0] dclk_sync_r;
    logic [SYNC_STAGES-1:0] drdy_sync_r;
    logic [NUM_CH-1:0]   dout_sync_r [SYNC_STAGES];
    logic                dclk_prev_r;
    logic                dclk_fall_r;
    logic [BCNT_W-1:0]   bit_cnt_r;
    logic [VAL_W-1:0]    sh_r [NUM_CH];
    logic [OUT_BITS-1:0] hold_r [NUM_CH];
    logic [NUM_CH-1:0]   rem_r;

    logic                done_s;
    logic                load_s;
    logic                drop_s;
    logic [CH_W-1:0]     load_idx_s;
    logic [NUM_CH-1:0]   load_rest_s;
    logic [NUM_CH-1:0]   nxt_rem_s;
    logic [CH_W-1:0]     nxt_idx_s;
    logic [NUM_CH-1:0]   nxt_rest_s;
    logic [OUT_BITS-1:0] load_word_s;

    function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = CH_W'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    function automatic logic [NUM_CH-1:0] clear_bit(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] r;
        r      = m;
        r[idx] = 1'b0;
        return r;
    endfunction

    assign adc_clk = div_r[1];

    // MCLK divider and reset forwarding to the converter
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            div_r       <= 2'd0;
            adc_n_reset <= 1'b0;
        end else begin
            div_r       <= div_r + 2'd1;
            adc_n_reset <= 1'b1;
        end
    end

    // Input synchronisers and registered DCLK falling-edge strobe
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            dclk_sync_r <= '0;
            drdy_sync_r <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) dout_sync_r[s] <= '0;
            dclk_prev_r <= 1'b0;
            dclk_fall_r <= 1'b0;
        end else begin
            dclk_sync_r[0] <= adc_dclk;
            drdy_sync_r[0] <= adc_n_drdy;
            dout_sync_r[0] <= adc_dout;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                dclk_sync_r[s] <= dclk_sync_r[s-1];
                drdy_sync_r[s] <= drdy_sync_r[s-1];
                dout_sync_r[s] <= dout_sync_r[s-1];
            end
            dclk_prev_r <= dclk_sync_r[SYNC_STAGES-1];
            dclk_fall_r <= dclk_prev_r & ~dclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Capture FSM: shifts one bit per lane on each DCLK fall
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cap_state_r <= CAP_IDLE;
            bit_cnt_r   <= '0;
            for (int c = 0; c < NUM_CH; c++) sh_r[c] <= '0;
        end else begin
            case (cap_state_r)
                CAP_IDLE: begin
                    if (dclk_fall_r && drdy_sync_r[SYNC_STAGES-1]) begin
                        for (int c = 0; c < NUM_CH; c++) sh_r[c] <= VAL_W'(dout_sync_r[SYNC_STAGES-1][c]);
                        bit_cnt_r   <= BCNT_W'(1);
                        cap_state_r <= CAP_SHIFT;
                    end
                end
                CAP_SHIFT: begin
                    if (dclk_fall_r) begin
                        for (int c = 0; c < NUM_CH; c++)
                            sh_r[c] <= (sh_r[c] << 1) | VAL_W'(dout_sync_r[SYNC_STAGES-1][c]);
                        bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
                        if (bit_cnt_r == BCNT_W'(SAMPLE_BITS - 1)) cap_state_r <= CAP_DONE;
                    end
                end
                CAP_DONE: cap_state_r <= CAP_IDLE;
                default:  cap_state_r <= CAP_IDLE;
            endcase
        end
    end

    // Hand-off decision and next-channel selection
    always_comb begin
        done_s      = (cap_state_r == CAP_DONE) && acq_en && (ch_mask != '0);
        load_s      = done_s && (em_state_r == EM_IDLE);
        drop_s      = done_s && (em_state_r != EM_IDLE);
        load_idx_s  = lowest_idx(ch_mask);
        load_rest_s = clear_bit(ch_mask, load_idx_s);
        load_word_s = sh_r[load_idx_s][VAL_W-1 -: OUT_BITS];
        nxt_rem_s   = clear_bit(rem_r, lowest_idx(rem_r));
        nxt_idx_s   = lowest_idx(nxt_rem_s);
        nxt_rest_s  = clear_bit(nxt_rem_s, nxt_idx_s);
    end

    // Drop accounting; a clear in the same cycle as a drop wins
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            drop_count <= '0;
            overrun    <= 1'b0;
        end else if (clr_stats) begin
            drop_count <= '0;
            overrun    <= 1'b0;
        end else if (drop_s) begin
            if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
            overrun <= 1'b1;
        end
    end

    // Emit FSM: walks the buffered mask lowest channel first, no bubbles between words
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            em_state_r <= EM_IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= 3'd0;
            out_last   <= 1'b0;
            rem_r      <= '0;
            for (int c = 0; c < NUM_CH; c++) hold_r[c] <= '0;
        end else begin
            case (em_state_r)
                EM_IDLE: begin
                    if (load_s) begin
                        for (int c = 0; c < NUM_CH; c++) hold_r[c] <= sh_r[c][VAL_W-1 -: OUT_BITS];
                        rem_r      <= ch_mask;
                        out_data   <= load_word_s;
                        out_chan   <= 3'(load_idx_s);
                        out_last   <= (load_rest_s == '0);
                        out_valid  <= 1'b1;
                        em_state_r <= EM_SEND;
                    end
                end
                EM_SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            em_state_r <= EM_IDLE;
                        end else begin
                            rem_r    <= nxt_rem_s;
                            out_data <= hold_r[nxt_idx_s];
                            out_chan <= 3'(nxt_idx_s);
                            out_last <= (nxt_rest_s == '0);
                        end
                    end
                end
                default: em_state_r <= EM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: a 16-bit and a 24-bit instance share the ADC lanes,
// a frame-level model predicts the word streams and drop statistics.
module tb_adc_frame_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset, adc_n_drdy, adc_dclk, acq_en, out_ready, clr_stats;
    logic [3:0]  adc_dout, ch_mask;
    logic        adc_clk, adc_n_reset, out_last, out_valid, overrun;
    logic [15:0] out_data, drop_count;
    logic [2:0]  out_chan;

    logic        acq24 = 1'b1, ready24 = 1'b1, clr24 = 1'b0;
    logic [3:0]  mask24 = 4'b1000;
    logic        d24_adc_clk, d24_adc_n_reset, d24_last, d24_valid, d24_overrun;
    logic [23:0] d24_data;
    logic [2:0]  d24_chan;
    logic [15:0] d24_drops;

    adc_frame_packer dut (
        .clk(clk), .n_reset(n_reset), .adc_clk(adc_clk), .adc_n_reset(adc_n_reset),
        .adc_n_drdy(adc_n_drdy), .adc_dclk(adc_dclk), .adc_dout(adc_dout), .acq_en(acq_en),
        .ch_mask(ch_mask), .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count),
        .overrun(overrun), .clr_stats(clr_stats)
    );

    adc_frame_packer #(.OUT_BITS(24)) dut24 (
        .clk(clk), .n_reset(n_reset), .adc_clk(d24_adc_clk), .adc_n_reset(d24_adc_n_reset),
        .adc_n_drdy(adc_n_drdy), .adc_dclk(adc_dclk), .adc_dout(adc_dout), .acq_en(acq24),
        .ch_mask(mask24), .out_data(d24_data), .out_chan(d24_chan), .out_last(d24_last),
        .out_valid(d24_valid), .out_ready(ready24), .drop_count(d24_drops),
        .overrun(d24_overrun), .clr_stats(clr24)
    );

    typedef struct packed {logic [23:0] data; logic [2:0] chan; logic last;} word_t;
    word_t exp_q[$], exp24_q[$], log_q[$], log24_q[$];
    int    exp_drops = 0;
    int    errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: value field = bits [23:8] (16-bit) or [23:0] (24-bit) of the sample
    task automatic model_frame(input logic [3:0][31:0] lanes);
        word_t w;
        if (acq_en && ch_mask != 4'd0) begin
            if (exp_q.size() != 0) begin
                if (exp_drops < 65535) exp_drops++;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (ch_mask[c]) begin
                        w.data = (lanes[c] >> 8) & 32'h0000FFFF;
                        w.chan = 3'(c);
                        w.last = ((ch_mask >> (c + 1)) == 4'd0);
                        exp_q.push_back(w);
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (mask24[c]) begin
                w.data = lanes[c][23:0];
                w.chan = 3'(c);
                w.last = ((mask24 >> (c + 1)) == 4'd0);
                exp24_q.push_back(w);
            end
        end
    endtask

    task automatic send_frame(input logic [3:0][31:0] lanes, input int nbits, input bit chk_lat);
        for (int b = 0; b < nbits; b++) begin
            adc_n_drdy = (b == 0);
            for (int c = 0; c < 4; c++) adc_dout[c] = lanes[c][31-b];
            adc_dclk = 1'b1;
            repeat (4) tick();
            adc_dclk = 1'b0;
            if (b == 31) begin
                model_frame(lanes);
                if (chk_lat) begin
                    repeat (4) tick();
                    chk("latency_before", {31'd0, out_valid}, 32'd0);
                    tick();
                    chk("latency_at", {31'd0, out_valid}, 32'd1);
                    repeat (3) tick();
                end else begin
                    repeat (8) tick();
                end
            end else begin
                repeat (4) tick();
            end
        end
        adc_n_drdy = 1'b0;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        exp_q.delete();
        exp24_q.delete();
        exp_drops = 0;
        repeat (3) tick();
    endtask

    // Stream comparison for both instances against the model queues
    always @(negedge clk) begin
        word_t w;
        if (n_reset === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word: got data %h chan %0d, expected no word", out_data, out_chan);
            end else begin
                chk("word_data", {16'd0, out_data}, {8'd0, exp_q[0].data});
                chk("word_chan", {29'd0, out_chan}, {29'd0, exp_q[0].chan});
                chk("word_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                if (out_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    w.data = {8'd0, out_data}; w.chan = out_chan; w.last = out_last;
                    log_q.push_back(w);
                end
            end
        end
        if (n_reset === 1'b1 && d24_valid === 1'b1) begin
            if (exp24_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word24: got data %h chan %0d, expected no word", d24_data, d24_chan);
            end else begin
                chk("word24_data", {8'd0, d24_data}, {8'd0, exp24_q[0].data});
                chk("word24_chan", {29'd0, d24_chan}, {29'd0, exp24_q[0].chan});
                chk("word24_last", {31'd0, d24_last}, {31'd0, exp24_q[0].last});
                void'(exp24_q.pop_front());
                w.data = d24_data; w.chan = d24_chan; w.last = d24_last;
                log24_q.push_back(w);
            end
        end
    end

    logic [3:0][31:0] l1, l2;

    initial begin
        l1 = {32'h11111111, 32'h00FFFF00, 32'hA5ABCDEF, 32'hA5123456};
        l2 = {32'h7F800001, 32'h00C0FFEE, 32'h12876543, 32'hFF5555AA};
        adc_n_drdy = 1'b0; adc_dclk = 1'b0; adc_dout = 4'd0;
        acq_en = 1'b1; ch_mask = 4'b0111; out_ready = 1'b1; clr_stats = 1'b0;
        do_reset();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_chan", {29'd0, out_chan}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_drops", {16'd0, drop_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_adc_clk", {31'd0, adc_clk}, 32'd0);
        chk("rst_adc_n_reset", {31'd0, adc_n_reset}, 32'd0);
        n_reset = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("adc_clk_div", {31'd0, adc_clk}, ((j % 4) >= 2) ? 32'd1 : 32'd0);
            chk("adc_n_reset_run", {31'd0, adc_n_reset}, 32'd1);
        end

        // 1: three enabled channels, ready high
        log_q.delete();
        send_frame(l1, 32, 1'b1);
        repeat (10) tick();
        chk("t1_count", log_q.size(), 32'd3);
        if (log_q.size() == 3) begin
            chk("t1_w0", {log_q[0].data, log_q[0].chan, log_q[0].last}, {24'h001234, 3'd0, 1'b0});
            chk("t1_w1", {log_q[1].data, log_q[1].chan, log_q[1].last}, {24'h00ABCD, 3'd1, 1'b0});
            chk("t1_w2", {log_q[2].data, log_q[2].chan, log_q[2].last}, {24'h00FFFF, 3'd2, 1'b1});
        end

        // 2: backpressure on the second word
        log_q.delete();
        out_ready = 1'b0;
        send_frame(l1, 32, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t2_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'hABCD});
            tick();
        end
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t2_count", log_q.size(), 32'd3);
        if (log_q.size() == 3) begin
            chk("t2_w2", {log_q[2].data, log_q[2].chan, log_q[2].last}, {24'h00FFFF, 3'd2, 1'b1});
        end
        chk("t2_drops", {16'd0, drop_count}, 32'd0);

        // 3: stalled consumer, two frames dropped, then stats cleared and drained
        log_q.delete();
        out_ready = 1'b0;
        send_frame(l1, 32, 1'b0);
        send_frame(l2, 32, 1'b0);
        send_frame(l2, 32, 1'b0);
        chk("t3_held", {16'd0, out_data}, 32'h1234);
        chk("t3_drops", {16'd0, drop_count}, exp_drops);
        chk("t3_drops_lit", {16'd0, drop_count}, 32'd2);
        chk("t3_overrun", {31'd0, overrun}, 32'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        exp_drops = 0;
        tick();
        chk("t3_clr_drops", {16'd0, drop_count}, 32'd0);
        chk("t3_clr_overrun", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("t3_drain", log_q.size(), 32'd3);

        // 4: acquisition disabled at frame end, then a sparse mask
        log_q.delete();
        acq_en = 1'b0;
        send_frame(l2, 32, 1'b0);
        chk("t4_none", log_q.size(), 32'd0);
        chk("t4_drops", {16'd0, drop_count}, 32'd0);
        acq_en = 1'b1;
        ch_mask = 4'b1010;
        send_frame(l2, 32, 1'b0);
        repeat (4) tick();
        chk("t4_count", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("t4_w0", {log_q[0].data, log_q[0].chan, log_q[0].last}, {24'h008765, 3'd1, 1'b0});
            chk("t4_w1", {log_q[1].data, log_q[1].chan, log_q[1].last}, {24'h008000, 3'd3, 1'b1});
        end

        // 5: reset with a word pending and a frame half captured
        out_ready = 1'b0;
        ch_mask = 4'b0001;
        send_frame(l2, 32, 1'b0);
        send_frame(l1, 17, 1'b0);
        do_reset();
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_data", {13'd0, out_chan, out_data}, 32'd0);
        chk("t5_last", {31'd0, out_last}, 32'd0);
        n_reset = 1'b1;
        out_ready = 1'b1;
        log_q.delete();
        send_frame(l1, 32, 1'b0);
        repeat (4) tick();
        chk("t5_count", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            chk("t5_w0", {log_q[0].data, log_q[0].chan, log_q[0].last}, {24'h001234, 3'd0, 1'b1});
        end

        // 6: 24-bit instance, channel 3 only
        log24_q.delete();
        send_frame(l2, 32, 1'b0);
        repeat (4) tick();
        chk("t6_count", log24_q.size(), 32'd1);
        if (log24_q.size() == 1) begin
            chk("t6_w0", {log24_q[0].data, log24_q[0].chan, log24_q[0].last}, {24'h800001, 3'd3, 1'b1});
        end
        chk("t6_drops", {16'd0, d24_drops}, 32'd0);
        chk("end_drained", exp_q.size(), 32'd0);
        chk("end_drained24", exp24_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
